// File: rtl/scoreboard_pkg.sv
// Shared types and defaults for the scoreboard match controller and its timer.
package scoreboard_pkg;

  localparam int BW_DEFAULT        = 7;
  localparam int MAX_SCORE_DEFAULT = 99;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_WON   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_WAIT0 = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // Serve swaps every two points, and every point once both players sit at deuce.
  function automatic logic calc_serve(input logic        first_server,
                                      input int unsigned s1,
                                      input int unsigned s2,
                                      input int unsigned win_score);
    int unsigned total;
    logic        deuce;
    total = s1 + s2;
    deuce = ((s1 + 1) >= win_score) && ((s2 + 1) >= win_score);
    return first_server ^ (deuce ? total[0] : total[1]);
  endfunction

endpackage

// File: rtl/scoreboard_match_ctrl_timer.sv
// Blink and hold timing for the WON display; counts only while enabled and
// restarts from zero so every visit to WON sees the same blink phase.
module match_timer
  import scoreboard_pkg::*;
#(
  parameter int BLINK_HALF_MS = 250,
  parameter int WON_HOLD_MS   = 5000
) (
  input  logic clk_1khz_i,
  input  logic rst_ni,
  input  logic enable,
  input  logic restart,
  output logic blank_o,
  output logic hold_done_o
);

  localparam int HOLD_W  = $clog2(WON_HOLD_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_MS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WON_HOLD_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_MS - 1);

  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blank_q;

  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (restart || !enable) begin
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      // Hold counter saturates; the FSM leaves WON on hold_done anyway.
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blank_q     <= ~blank_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  assign blank_o     = blank_q;
  assign hold_done_o = enable && (hold_cnt_q == HOLD_LAST);

endmodule

// File: rtl/scoreboard_match_ctrl.sv
// Match controller: gates counter pulses, detects game wins, blinks the display
// and sequences the post-game clear and serve rotation.
module scoreboard_match_ctrl
  import scoreboard_pkg::*;
#(
  parameter int BW            = BW_DEFAULT,
  parameter int MAX_SCORE     = MAX_SCORE_DEFAULT,
  parameter int WIN_SCORE     = 11,
  parameter int WIN_MARGIN    = 2,
  parameter int BLINK_HALF_MS = 250,
  parameter int WON_HOLD_MS   = 5000
) (
  input  logic          clk_1khz_i,
  input  logic          rst_ni,
  input  logic          up_p1_i,
  input  logic          down_p1_i,
  input  logic          up_p2_i,
  input  logic          down_p2_i,
  input  logic [BW-1:0] score_p1_i,
  input  logic [BW-1:0] score_p2_i,
  output logic          up_p1_o,
  output logic          down_p1_o,
  output logic          up_p2_o,
  output logic          down_p2_o,
  output logic          clr_o,
  output logic          serve_p2_o,
  output logic [1:0]    winner_o,
  output logic          blank_o,
  output logic [1:0]    state_o
);

  localparam logic [BW:0] MAX_W    = (BW+1)'(MAX_SCORE);
  localparam logic [BW:0] WIN_W    = (BW+1)'(WIN_SCORE);
  localparam logic [BW:0] MARGIN_W = (BW+1)'(WIN_MARGIN);

  state_e  state_q, state_d;
  winner_e winner_q, winner_d;
  logic    first_server_q, serve_q;
  logic    up_p1_q, down_p1_q, up_p2_q, down_p2_q;
  logic    up_p1_d, down_p1_d, up_p2_d, down_p2_d;

  logic [BW:0] s1_w, s2_w;
  logic        win_p1, win_p2, both_zero;
  logic        up_ok_p1, dn_ok_p1, up_ok_p2, dn_ok_p2;
  logic        fix_p1, fix_p2;
  logic        timer_enable, timer_restart, hold_done;

  // One extra bit keeps score + margin from wrapping.
  assign s1_w = {1'b0, score_p1_i};
  assign s2_w = {1'b0, score_p2_i};

  assign win_p1    = (s1_w >= WIN_W) && (s1_w >= s2_w + MARGIN_W);
  assign win_p2    = (s2_w >= WIN_W) && (s2_w >= s1_w + MARGIN_W);
  assign both_zero = (score_p1_i == '0) && (score_p2_i == '0);

  assign up_ok_p1 = up_p1_i && !down_p1_i && (s1_w < MAX_W);
  assign dn_ok_p1 = down_p1_i && !up_p1_i && (score_p1_i != '0);
  assign up_ok_p2 = up_p2_i && !down_p2_i && (s2_w < MAX_W);
  assign dn_ok_p2 = down_p2_i && !up_p2_i && (score_p2_i != '0);

  // In WON only downs matter, so a simultaneous up does not cancel a correction.
  assign fix_p1 = down_p1_i && (score_p1_i != '0);
  assign fix_p2 = down_p2_i && (score_p2_i != '0);

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    up_p1_d   = 1'b0;
    down_p1_d = 1'b0;
    up_p2_d   = 1'b0;
    down_p2_d = 1'b0;
    unique case (state_q)
      ST_PLAY: begin
        if (win_p1) begin
          state_d  = ST_WON;
          winner_d = WIN_P1;
        end else if (win_p2) begin
          state_d  = ST_WON;
          winner_d = WIN_P2;
        end else begin
          up_p1_d   = up_ok_p1;
          down_p1_d = dn_ok_p1;
          up_p2_d   = up_ok_p2;
          down_p2_d = dn_ok_p2;
        end
      end
      ST_WON: begin
        down_p1_d = fix_p1;
        down_p2_d = fix_p2;
        if (fix_p1 || fix_p2) begin
          state_d  = ST_PLAY;
          winner_d = WIN_NONE;
        end else if (hold_done) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (both_zero) begin
          state_d  = ST_PLAY;
          winner_d = WIN_NONE;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_PLAY;
      winner_q       <= WIN_NONE;
      first_server_q <= 1'b0;
      serve_q        <= 1'b0;
      up_p1_q        <= 1'b0;
      down_p1_q      <= 1'b0;
      up_p2_q        <= 1'b0;
      down_p2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      up_p1_q   <= up_p1_d;
      down_p1_q <= down_p1_d;
      up_p2_q   <= up_p2_d;
      down_p2_q <= down_p2_d;
      if (state_q == ST_CLEAR) begin
        first_server_q <= ~first_server_q;
      end
      serve_q <= calc_serve(first_server_q, 32'(score_p1_i), 32'(score_p2_i), WIN_SCORE);
    end
  end

  // Timers run only for a continuous stay in WON and clear on the edge that leaves it.
  assign timer_enable  = (state_q == ST_WON);
  assign timer_restart = (state_q != ST_WON) || (state_d != ST_WON);

  match_timer #(
    .BLINK_HALF_MS(BLINK_HALF_MS),
    .WON_HOLD_MS  (WON_HOLD_MS)
  ) u_match_timer (
    .clk_1khz_i (clk_1khz_i),
    .rst_ni     (rst_ni),
    .enable     (timer_enable),
    .restart    (timer_restart),
    .blank_o    (blank_o),
    .hold_done_o(hold_done)
  );

  assign up_p1_o    = up_p1_q;
  assign down_p1_o  = down_p1_q;
  assign up_p2_o    = up_p2_q;
  assign down_p2_o  = down_p2_q;
  assign clr_o      = (state_q == ST_CLEAR);
  assign serve_p2_o = serve_q;
  assign winner_o   = winner_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_scoreboard_match_ctrl.sv
// Bench for scoreboard_match_ctrl: gating vector table, hand-written WON/CLEAR,
// deuce and mid-WON reset sequences, then randomized play against a reference model.
module tb_scoreboard_match_ctrl;

  localparam int WIN_SCORE  = 11;
  localparam int WIN_MARGIN = 2;
  localparam int MAX_SCORE  = 99;

  logic       clk_1khz_i = 1'b0;
  logic       rst_ni     = 1'b0;
  logic       up_p1_i, down_p1_i, up_p2_i, down_p2_i;
  logic [6:0] score_p1_i, score_p2_i;
  logic       up_p1_o, down_p1_o, up_p2_o, down_p2_o;
  logic       clr_o, serve_p2_o, blank_o;
  logic [1:0] winner_o, state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int fs_model = 0;
  int won_k    = 0;

  typedef struct packed {
    logic       u1, d1, u2, d2;
    logic [6:0] s1, s2;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [11];

  always #5 clk_1khz_i = ~clk_1khz_i;

  scoreboard_match_ctrl dut (
    .clk_1khz_i(clk_1khz_i),
    .rst_ni    (rst_ni),
    .up_p1_i   (up_p1_i),
    .down_p1_i (down_p1_i),
    .up_p2_i   (up_p2_i),
    .down_p2_i (down_p2_i),
    .score_p1_i(score_p1_i),
    .score_p2_i(score_p2_i),
    .up_p1_o   (up_p1_o),
    .down_p1_o (down_p1_o),
    .up_p2_o   (up_p2_o),
    .down_p2_o (down_p2_o),
    .clr_o     (clr_o),
    .serve_p2_o(serve_p2_o),
    .winner_o  (winner_o),
    .blank_o   (blank_o),
    .state_o   (state_o)
  );

  function automatic int ref_serve(int fs, int a, int b);
    int total;
    total = a + b;
    if (a >= WIN_SCORE - 1 && b >= WIN_SCORE - 1) return fs ^ (total % 2);
    return fs ^ ((total / 2) % 2);
  endfunction

  function automatic int ref_winner(int a, int b);
    if (a >= WIN_SCORE && a >= b + WIN_MARGIN) return 1;
    if (b >= WIN_SCORE && b >= a + WIN_MARGIN) return 2;
    return 0;
  endfunction

  function automatic logic [3:0] ref_pulses(logic u1, logic d1, logic u2, logic d2, int a, int b);
    logic [3:0] r;
    r[3] = u1 && !d1 && (a < MAX_SCORE);
    r[2] = d1 && !u1 && (a > 0);
    r[1] = u2 && !d2 && (b < MAX_SCORE);
    r[0] = d2 && !u2 && (b > 0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic u1, input logic d1, input logic u2, input logic d2,
                               input int s1, input int s2);
    up_p1_i    = u1;
    down_p1_i  = d1;
    up_p2_i    = u2;
    down_p2_i  = d2;
    score_p1_i = 7'(s1);
    score_p2_i = 7'(s2);
  endtask

  task automatic step();
    @(posedge clk_1khz_i);
    #1;
  endtask

  task automatic run_to(input int target);
    while (won_k < target) begin
      step();
      won_k++;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd5,  7'd3,  4'b1000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0,  7'd3,  4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd98, 7'd99, 4'b0000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd98, 7'd99, 4'b1000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd5,  7'd5,  4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd3,  7'd4,  4'b1010};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd3,  7'd4,  4'b0101};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd2,  7'd0,  4'b1000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd1,  7'd1,  4'b0001};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd4,  7'd4,  4'b0000};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd10, 7'd9,  4'b0110};

    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
    repeat (10) step();
    checkOutput("reset_pulses", {up_p1_o, down_p1_o, up_p2_o, down_p2_o}, 0);
    checkOutput("reset_clr", clr_o, 0);
    checkOutput("reset_serve", serve_p2_o, 0);
    checkOutput("reset_winner", winner_o, 0);
    checkOutput("reset_blank", blank_o, 0);
    checkOutput("reset_state", state_o, 0);

    begin
      int st [4][2];
      st = '{'{0, 0}, '{1, 0}, '{1, 1}, '{2, 2}};
      for (int i = 0; i < 4; i++) begin
        applyStimulus(0, 0, 0, 0, st[i][0], st[i][1]);
        step();
        checkOutput("serve_basic", serve_p2_o, ref_serve(fs_model, st[i][0], st[i][1]));
      end
    end

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].u1, vecs[i].d1, vecs[i].u2, vecs[i].d2, int'(vecs[i].s1), int'(vecs[i].s2));
      step();
      checkOutput($sformatf("vec%0d_pulses", i), {up_p1_o, down_p1_o, up_p2_o, down_p2_o}, vecs[i].exp);
    end

    // P1 climbs to 11 against 5, then the full WON -> CLEAR -> WAIT0 -> PLAY cycle.
    for (int s = 0; s < 11; s++) begin
      applyStimulus(1, 0, 0, 0, s, 5);
      step();
      checkOutput("climb_up_p1", up_p1_o, 1);
      checkOutput("climb_no_win", winner_o, 0);
    end
    applyStimulus(0, 0, 0, 0, 11, 5);
    step();
    won_k = 0;
    checkOutput("win_winner", winner_o, ref_winner(11, 5));
    checkOutput("win_state", state_o, 1);
    applyStimulus(1, 0, 0, 0, 11, 5);
    step();
    won_k++;
    checkOutput("won_up_dropped", up_p1_o, 0);
    applyStimulus(0, 0, 0, 0, 11, 5);
    run_to(249);
    checkOutput("blank_249", blank_o, 0);
    run_to(250);
    checkOutput("blank_250", blank_o, 1);
    run_to(499);
    checkOutput("blank_499", blank_o, 1);
    run_to(500);
    checkOutput("blank_500", blank_o, 0);
    run_to(4999);
    checkOutput("hold_4999_clr", clr_o, 0);
    checkOutput("hold_4999_state", state_o, 1);
    run_to(5000);
    checkOutput("clear_clr", clr_o, 1);
    checkOutput("clear_state", state_o, 2);
    checkOutput("clear_blank", blank_o, 0);
    checkOutput("clear_winner", winner_o, 1);
    fs_model ^= 1;
    run_to(5001);
    checkOutput("wait0_clr", clr_o, 0);
    checkOutput("wait0_state", state_o, 3);
    applyStimulus(1, 0, 0, 0, 11, 5);
    step();
    checkOutput("wait0_up_dropped", up_p1_o, 0);
    checkOutput("wait0_holds", state_o, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("replay_state", state_o, 0);
    checkOutput("replay_winner", winner_o, 0);
    checkOutput("replay_serve", serve_p2_o, ref_serve(fs_model, 0, 0));

    // Deuce: no win at a one-point lead, win once the lead reaches two.
    begin
      int ds [3][2];
      ds = '{'{10, 10}, '{11, 10}, '{12, 10}};
      for (int i = 0; i < 3; i++) begin
        applyStimulus(0, 0, 0, 0, ds[i][0], ds[i][1]);
        step();
        checkOutput("deuce_serve", serve_p2_o, ref_serve(fs_model, ds[i][0], ds[i][1]));
        checkOutput("deuce_winner", winner_o, ref_winner(ds[i][0], ds[i][1]));
      end
    end
    applyStimulus(0, 1, 0, 0, 12, 10);
    step();
    checkOutput("fix_down_p1", down_p1_o, 1);
    checkOutput("fix_winner", winner_o, 0);
    checkOutput("fix_state", state_o, 0);
    begin
      int ls [5][2];
      ls = '{'{11, 11}, '{12, 11}, '{12, 12}, '{13, 12}, '{14, 12}};
      for (int i = 0; i < 5; i++) begin
        applyStimulus(0, 0, 0, 0, ls[i][0], ls[i][1]);
        step();
        checkOutput("lead_winner", winner_o, ref_winner(ls[i][0], ls[i][1]));
        if (i < 4) checkOutput("lead_serve", serve_p2_o, ref_serve(fs_model, ls[i][0], ls[i][1]));
      end
    end
    checkOutput("lead_state", state_o, 1);
    applyStimulus(0, 0, 0, 1, 14, 12);
    step();
    checkOutput("fix_down_p2", down_p2_o, 1);
    checkOutput("fix2_state", state_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();

    // Reset asserted deep inside WON.
    applyStimulus(0, 0, 0, 0, 11, 5);
    step();
    won_k = 0;
    checkOutput("rewin_state", state_o, 1);
    run_to(2000);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_pulses", {up_p1_o, down_p1_o, up_p2_o, down_p2_o}, 0);
    checkOutput("midrst_clr", clr_o, 0);
    checkOutput("midrst_serve", serve_p2_o, 0);
    checkOutput("midrst_winner", winner_o, 0);
    checkOutput("midrst_blank", blank_o, 0);
    checkOutput("midrst_state", state_o, 0);
    fs_model = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Randomized play that never produces a win, checked against the model.
    for (int i = 0; i < 300; i++) begin
      int   a, b, r;
      logic u1, d1, u2, d2;
      logic [9:0] exp_v;
      r = int'($urandom_range(0, 3));
      if (r == 0) begin
        a = int'($urandom_range(0, 10));
        b = int'($urandom_range(0, 10));
      end else if (r == 1) begin
        a = ($urandom_range(0, 1) == 1) ? 99 : 0;
        b = (a == 0) ? int'($urandom_range(0, 1)) : 98 + int'($urandom_range(0, 1));
      end else begin
        a = int'($urandom_range(0, 99));
        b = a + int'($urandom_range(0, 2)) - 1;
        if (b < 0) b = 0;
        if (b > 99) b = 99;
      end
      u1 = ($urandom_range(0, 3) == 0);
      d1 = ($urandom_range(0, 3) == 0);
      u2 = ($urandom_range(0, 3) == 0);
      d2 = ($urandom_range(0, 3) == 0);
      applyStimulus(u1, d1, u2, d2, a, b);
      step();
      exp_v = {ref_pulses(u1, d1, u2, d2, a, b), 1'(ref_serve(fs_model, a, b)),
               2'(ref_winner(a, b)), 2'b00, 1'b0};
      checkOutput($sformatf("rand%0d_s%0d_%0d", i, a, b),
                  {up_p1_o, down_p1_o, up_p2_o, down_p2_o, serve_p2_o, winner_o, state_o, clr_o},
                  exp_v);
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
